// File: rtl/ahb_mm_arbiter_if.sv
// rtl/ahb_mm_arbiter_if.sv - two-manager AHB-Lite arbiter bus bundle
`timescale 1ns/1ps
interface ahb_mm_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] i_haddr_m0, i_haddr_m1;
    logic [1:0]            i_htrans_m0, i_htrans_m1;
    logic                  i_hwrite_m0, i_hwrite_m1;
    logic [2:0]            i_hsize_m0, i_hsize_m1;
    logic [2:0]            i_hburst_m0, i_hburst_m1;
    logic [DATA_WIDTH-1:0] i_hwdata_m0, i_hwdata_m1;
    logic                  o_hready_m0, o_hready_m1;
    logic                  o_hresp_m0, o_hresp_m1;
    logic [DATA_WIDTH-1:0] o_hrdata_m0, o_hrdata_m1;
    logic [ADDR_WIDTH-1:0] o_haddr;
    logic [1:0]            o_htrans;
    logic                  o_hwrite;
    logic [2:0]            o_hsize;
    logic [2:0]            o_hburst;
    logic [DATA_WIDTH-1:0] o_hwdata;
    logic                  i_hreadyout;
    logic                  i_hresp;
    logic [DATA_WIDTH-1:0] i_hrdata;
    logic                  o_hmaster;

    // Arbiter side
    modport slave (
        input  i_haddr_m0, i_haddr_m1, i_htrans_m0, i_htrans_m1,
        input  i_hwrite_m0, i_hwrite_m1, i_hsize_m0, i_hsize_m1,
        input  i_hburst_m0, i_hburst_m1, i_hwdata_m0, i_hwdata_m1,
        input  i_hreadyout, i_hresp, i_hrdata,
        output o_hready_m0, o_hready_m1, o_hresp_m0, o_hresp_m1,
        output o_hrdata_m0, o_hrdata_m1, o_haddr, o_htrans, o_hwrite,
        output o_hsize, o_hburst, o_hwdata, o_hmaster
    );

    // Environment side (managers plus subordinate)
    modport master (
        output i_haddr_m0, i_haddr_m1, i_htrans_m0, i_htrans_m1,
        output i_hwrite_m0, i_hwrite_m1, i_hsize_m0, i_hsize_m1,
        output i_hburst_m0, i_hburst_m1, i_hwdata_m0, i_hwdata_m1,
        output i_hreadyout, i_hresp, i_hrdata,
        input  o_hready_m0, o_hready_m1, o_hresp_m0, o_hresp_m1,
        input  o_hrdata_m0, o_hrdata_m1, o_haddr, o_htrans, o_hwrite,
        input  o_hsize, o_hburst, o_hwdata, o_hmaster
    );
endinterface

// File: rtl/ahb_mm_arbiter.sv
// rtl/ahb_mm_arbiter.sv - two-manager AHB-Lite round-robin arbiter and mux
`timescale 1ns/1ps
module ahb_mm_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic               i_hclk,
    input  logic               i_hreset,
    ahb_mm_arbiter_if.slave    bus
);
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_M0   = 2'd1;
    localparam logic [1:0] OWN_M1   = 2'd2;

    logic       gnt;
    logic [1:0] downer;
    logic [4:0] beats;
    logic       last;

    logic [ADDR_WIDTH-1:0] fwd_haddr;
    logic [1:0]            fwd_htrans;
    logic [2:0]            fwd_hburst;
    logic [DATA_WIDTH-1:0] wdata_mux;
    logic                  req0, req1, req_own, req_other;
    logic                  rearb, do_switch;
    logic [4:0]            burst_beats;

    // Address/control mux follows the address-phase owner
    always_comb begin
        fwd_haddr    = gnt ? bus.i_haddr_m1  : bus.i_haddr_m0;
        fwd_htrans   = gnt ? bus.i_htrans_m1 : bus.i_htrans_m0;
        fwd_hburst   = gnt ? bus.i_hburst_m1 : bus.i_hburst_m0;
        bus.o_haddr  = fwd_haddr;
        bus.o_htrans = fwd_htrans;
        bus.o_hburst = fwd_hburst;
        bus.o_hwrite = gnt ? bus.i_hwrite_m1 : bus.i_hwrite_m0;
        bus.o_hsize  = gnt ? bus.i_hsize_m1  : bus.i_hsize_m0;
        bus.o_hmaster = gnt;
    end

    // Data-phase routing follows the data owner, which may lag the grant by a beat
    always_comb begin
        case (downer)
            OWN_M0:  wdata_mux = bus.i_hwdata_m0;
            OWN_M1:  wdata_mux = bus.i_hwdata_m1;
            default: wdata_mux = '0;
        endcase
        bus.o_hwdata    = wdata_mux;
        bus.o_hresp_m0  = (downer == OWN_M0) ? bus.i_hresp : 1'b0;
        bus.o_hresp_m1  = (downer == OWN_M1) ? bus.i_hresp : 1'b0;
        bus.o_hrdata_m0 = bus.i_hrdata;
        bus.o_hrdata_m1 = bus.i_hrdata;
        // The loser sees ready only while idle, so it holds its request stable
        bus.o_hready_m0 = gnt ? (bus.i_htrans_m0 == TRANS_IDLE) : bus.i_hreadyout;
        bus.o_hready_m1 = gnt ? bus.i_hreadyout : (bus.i_htrans_m1 == TRANS_IDLE);
    end

    // Arbitration decision; only evaluated when the owner has gone idle outside a burst
    always_comb begin
        req0      = bus.i_htrans_m0 != TRANS_IDLE;
        req1      = bus.i_htrans_m1 != TRANS_IDLE;
        req_own   = gnt ? req1 : req0;
        req_other = gnt ? req0 : req1;
        rearb     = bus.i_hreadyout && (fwd_htrans == TRANS_IDLE) && (beats == 5'd0);
        do_switch = 1'b0;
        if (rearb && req_other) begin
            // On a tie the manager that was not granted last wins
            do_switch = req_own ? (last == gnt) : 1'b1;
        end
        case (fwd_hburst[2:1])
            2'b01:   burst_beats = 5'd3;
            2'b10:   burst_beats = 5'd7;
            2'b11:   burst_beats = 5'd15;
            default: burst_beats = 5'd0;
        endcase
    end

    // Grant and last-owner registers
    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            gnt  <= 1'b0;
            last <= 1'b1;
        end else if (do_switch) begin
            gnt  <= ~gnt;
            last <= ~gnt;
        end
    end

    // Data owner tracks every accepted address phase
    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            downer <= OWN_NONE;
        end else if (bus.i_hreadyout) begin
            if (fwd_htrans[1])
                downer <= gnt ? OWN_M1 : OWN_M0;
            else
                downer <= OWN_NONE;
        end
    end

    // Burst lock counter; an ERROR response abandons the remaining beats
    always_ff @(posedge i_hclk or negedge i_hreset) begin
        if (!i_hreset) begin
            beats <= 5'd0;
        end else if (bus.i_hresp) begin
            beats <= 5'd0;
        end else if (bus.i_hreadyout) begin
            if (fwd_htrans == TRANS_NONSEQ)
                beats <= burst_beats;
            else if (fwd_htrans == TRANS_SEQ && beats != 5'd0)
                beats <= beats - 5'd1;
        end
    end
endmodule

// File: tb/tb_ahb_mm_arbiter.sv
// tb/tb_ahb_mm_arbiter.sv - directed vector bench for ahb_mm_arbiter
`timescale 1ns/1ps
module tb_ahb_mm_arbiter;
    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] S = 2'b11;

    typedef struct packed {
        logic        master;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  burst;
        logic [31:0] wdata;
        logic        rdy0, rdy1, resp0, resp1;
        logic [31:0] rd0, rd1;
    } exp_t;

    typedef struct {
        logic [1:0] t0; logic [31:0] a0; logic [2:0] b0; logic w0; logic [31:0] d0;
        logic [1:0] t1; logic [31:0] a1; logic [2:0] b1; logic w1; logic [31:0] d1;
        logic rdy; logic resp; logic [31:0] rd;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    ahb_mm_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();
    ahb_mm_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_hclk(clk), .i_hreset(rst_n), .bus(bus)
    );

    task automatic set_in(input logic [1:0] t0, input logic [31:0] a0, input logic [2:0] b0,
                          input logic w0, input logic [31:0] d0,
                          input logic [1:0] t1, input logic [31:0] a1, input logic [2:0] b1,
                          input logic w1, input logic [31:0] d1,
                          input logic rdy, input logic resp, input logic [31:0] rd);
        bus.i_htrans_m0 = t0; bus.i_haddr_m0 = a0; bus.i_hburst_m0 = b0;
        bus.i_hwrite_m0 = w0; bus.i_hwdata_m0 = d0;
        bus.i_htrans_m1 = t1; bus.i_haddr_m1 = a1; bus.i_hburst_m1 = b1;
        bus.i_hwrite_m1 = w1; bus.i_hwdata_m1 = d1;
        bus.i_hreadyout = rdy; bus.i_hresp = resp; bus.i_hrdata = rd;
    endtask

    task automatic add(input logic [1:0] t0, input logic [31:0] a0, input logic [2:0] b0,
                       input logic w0, input logic [31:0] d0,
                       input logic [1:0] t1, input logic [31:0] a1, input logic [2:0] b1,
                       input logic w1, input logic [31:0] d1,
                       input logic rdy, input logic resp, input logic [31:0] rd,
                       input logic em, input logic [1:0] et, input logic [31:0] ea,
                       input logic ew, input logic [2:0] eb, input logic [31:0] ewd,
                       input logic er0, input logic er1, input logic ep0, input logic ep1);
        vec_t v;
        v.t0 = t0; v.a0 = a0; v.b0 = b0; v.w0 = w0; v.d0 = d0;
        v.t1 = t1; v.a1 = a1; v.b1 = b1; v.w1 = w1; v.d1 = d1;
        v.rdy = rdy; v.resp = resp; v.rd = rd;
        v.e = '{master: em, trans: et, addr: ea, write: ew, burst: eb, wdata: ewd,
                rdy0: er0, rdy1: er1, resp0: ep0, resp1: ep1, rd0: rd, rd1: rd};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic reset_pulse();
        set_in(I, 0, 0, 0, 0, I, 0, 0, 0, 0, 1, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t act;
        bus.i_hsize_m0 = 3'b010;
        bus.i_hsize_m1 = 3'b010;

        // reset values: outputs come from m0's inputs, stalled m1 sees ready low
        set_in(I, 0, 0, 0, 0, N, 'h100, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_master", 64'(bus.o_hmaster), 0);
        chk("rst_rdy0_follows_sub", 64'(bus.o_hready_m0), 0);
        chk("rst_rdy1_stalled", 64'(bus.o_hready_m1), 0);
        chk("rst_trans", 64'(bus.o_htrans), 0);
        reset_pulse();

        // t0 a0 b0 w0 d0 | t1 a1 b1 w1 d1 | rdy resp rd | master trans addr write burst wdata rdy0 rdy1 resp0 resp1
        add(I, 0, 0, 0, 0,          I, 0, 0, 0, 0,          1, 0, 0,       0, I, 0, 0, 0, 0,        1, 1, 0, 0);
        add(N, 'h10, 0, 1, 0,       I, 0, 0, 0, 0,          1, 0, 0,       0, N, 'h10, 1, 0, 0,     1, 1, 0, 0);
        add(I, 0, 0, 0, 'hAA,       I, 0, 0, 0, 0,          1, 1, 0,       0, I, 0, 0, 0, 'hAA,     1, 1, 1, 0);
        add(N, 'h20, 3, 0, 5,       N, 'h100, 0, 1, 'h77,   1, 0, 0,       0, N, 'h20, 0, 3, 0,     1, 0, 0, 0);
        add(S, 'h24, 3, 0, 5,       N, 'h100, 0, 1, 'h77,   1, 0, 'h1111,  0, S, 'h24, 0, 3, 5,     1, 0, 0, 0);
        add(S, 'h28, 3, 0, 5,       N, 'h100, 0, 1, 'h77,   0, 0, 0,       0, S, 'h28, 0, 3, 5,     0, 0, 0, 0);
        add(S, 'h28, 3, 0, 5,       N, 'h100, 0, 1, 'h77,   1, 0, 'h2222,  0, S, 'h28, 0, 3, 5,     1, 0, 0, 0);
        add(S, 'h2C, 3, 0, 5,       N, 'h100, 0, 1, 'h77,   1, 0, 'h3333,  0, S, 'h2C, 0, 3, 5,     1, 0, 0, 0);
        add(I, 'h30, 0, 0, 5,       N, 'h100, 0, 1, 'h77,   1, 0, 'h4444,  0, I, 'h30, 0, 0, 5,     1, 0, 0, 0);
        add(I, 0, 0, 0, 0,          N, 'h100, 0, 1, 'h77,   1, 0, 0,       1, N, 'h100, 1, 0, 0,    1, 1, 0, 0);
        add(N, 'h200, 0, 1, 0,      I, 0, 0, 0, 'h77,       1, 1, 0,       1, I, 0, 0, 0, 'h77,     0, 1, 0, 1);
        add(N, 'h200, 0, 1, 0,      N, 'h300, 3, 0, 'h77,   1, 0, 0,       0, N, 'h200, 1, 0, 0,    1, 0, 0, 0);
        add(I, 0, 0, 0, 'hBB,       N, 'h300, 3, 0, 'h77,   1, 0, 0,       0, I, 0, 0, 0, 'hBB,     1, 0, 0, 0);
        add(N, 'h400, 0, 1, 0,      N, 'h300, 3, 0, 'h77,   1, 0, 0,       1, N, 'h300, 0, 3, 0,    0, 1, 0, 0);
        add(N, 'h400, 0, 1, 0,      I, 0, 0, 0, 'h99,       1, 0, 0,       1, I, 0, 0, 0, 'h99,     0, 1, 0, 0);
        add(N, 'h400, 0, 1, 0,      I, 0, 0, 0, 'h99,       1, 1, 0,       1, I, 0, 0, 0, 0,        0, 1, 0, 0);
        add(N, 'h400, 0, 1, 0,      I, 0, 0, 0, 'h99,       1, 0, 0,       1, I, 0, 0, 0, 0,        0, 1, 0, 0);
        add(N, 'h400, 0, 1, 0,      I, 0, 0, 0, 0,          1, 0, 0,       0, N, 'h400, 1, 0, 0,    1, 1, 0, 0);

        foreach (tbl[k]) begin
            @(negedge clk);
            set_in(tbl[k].t0, tbl[k].a0, tbl[k].b0, tbl[k].w0, tbl[k].d0,
                   tbl[k].t1, tbl[k].a1, tbl[k].b1, tbl[k].w1, tbl[k].d1,
                   tbl[k].rdy, tbl[k].resp, tbl[k].rd);
            #1;
            act = '{master: bus.o_hmaster, trans: bus.o_htrans, addr: bus.o_haddr,
                    write: bus.o_hwrite, burst: bus.o_hburst, wdata: bus.o_hwdata,
                    rdy0: bus.o_hready_m0, rdy1: bus.o_hready_m1,
                    resp0: bus.o_hresp_m0, resp1: bus.o_hresp_m1,
                    rd0: bus.o_hrdata_m0, rd1: bus.o_hrdata_m1};
            n_assert++;
            if (act !== tbl[k].e) begin
                n_fail++;
                $display("FAIL vec%0d: got %h expected %h", k, act, tbl[k].e);
            end
        end

        // wait-state read by m1 while m0 requests: no switch until the data phase completes
        reset_pulse();
        set_in(I, 0, 0, 0, 0, N, 'h40, 0, 0, 0, 1, 0, 0);
        #1 chk("wr_pre_master", 64'(bus.o_hmaster), 0);
        @(negedge clk);
        set_in(N, 'h80, 0, 0, 0, N, 'h40, 0, 0, 0, 1, 0, 0);
        #1 chk("wr_addr_m1", {31'(bus.o_hmaster), bus.o_haddr}, {31'd1, 32'h40});
        chk("wr_rdy0_stall", 64'(bus.o_hready_m0), 0);
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            set_in(N, 'h80, 0, 0, 0, I, 0, 0, 0, 0, 0, 0, 0);
            #1 chk("wr_wait_hold", {bus.o_hmaster, bus.o_hready_m0, bus.o_hready_m1}, 64'b100);
        end
        @(negedge clk);
        set_in(N, 'h80, 0, 0, 0, I, 0, 0, 0, 0, 1, 0, 'hDEAD);
        #1 chk("wr_rdata_m1", {bus.o_hmaster, bus.o_hready_m1, bus.o_hrdata_m1}, {2'b11, 32'hDEAD});
        @(negedge clk);
        #1 chk("wr_switch_m0", {bus.o_hmaster, bus.o_htrans, bus.o_haddr}, {3'b010, 32'h80});

        // asynchronous reset during the 3rd beat of m1's INCR8
        reset_pulse();
        set_in(I, 0, 0, 0, 0, N, 'h500, 5, 0, 0, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        set_in(I, 0, 0, 0, 0, S, 'h504, 5, 0, 0, 1, 0, 0);
        @(negedge clk);
        set_in(N, 'h600, 0, 0, 0, S, 'h508, 5, 0, 0, 1, 0, 0);
        #1 chk("mr_before", {bus.o_hmaster, dut.beats}, {1'b1, 5'd6});
        #2 rst_n = 1'b0;
        #1 chk("mr_master", 64'(bus.o_hmaster), 0);
        chk("mr_trans_addr", {bus.o_htrans, bus.o_haddr}, {2'b10, 32'h600});
        chk("mr_regs", {dut.beats, dut.downer, dut.last}, {5'd0, 2'd0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_mm_arbiter.md
Name: ahb_mm_arbiter

Overview:
- Two-manager AHB-Lite arbiter and multiplexer. It sits between two AHB_manager instances and a single subordinate bus feeding AHB_subordinate.
- Grants the address phase to one manager at a time and locks the grant for fixed-length bursts.
- Stalls the losing manager via its HREADY and routes the data-phase signals to the correct owner.
- Round-robin fairness, with the grant parked on the last owner.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width

Ports:
i_hclk  in  1  bus clock, all timing on rising edge
i_hreset  in  1  asynchronous active-low reset
i_haddr_m0 / i_haddr_m1  in  ADDR_WIDTH  manager address
i_htrans_m0 / i_htrans_m1  in  2  manager transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
i_hwrite_m0 / i_hwrite_m1  in  1  manager direction
i_hsize_m0 / i_hsize_m1  in  3  manager size
i_hburst_m0 / i_hburst_m1  in  3  manager burst type
i_hwdata_m0 / i_hwdata_m1  in  DATA_WIDTH  manager write data
o_hready_m0 / o_hready_m1  out  1  per-manager ready
o_hresp_m0 / o_hresp_m1  out  1  per-manager response
o_hrdata_m0 / o_hrdata_m1  out  DATA_WIDTH  read data (broadcast)
o_haddr, o_htrans, o_hwrite, o_hsize, o_hburst  out  as above  subordinate address/control
o_hwdata  out  DATA_WIDTH  subordinate write data
i_hreadyout  in  1  subordinate ready
i_hresp  in  1  subordinate response
i_hrdata  in  DATA_WIDTH  subordinate read data
o_hmaster  out  1  current address-phase owner

Behaviour:
- Registers:
  - gnt (1b): address owner.
  - downer (2b): none / m0 / m1.
  - beats (5b): remaining beats of a fixed burst.
  - last (1b): last granted manager.
- Reset values: gnt=0, last=1, downer=none, beats=0.
  - Outputs at reset are combinational from m0's inputs.
  - o_hmaster=0, o_hready_m0=i_hreadyout.
  - o_hready_m1=1 if i_htrans_m1==IDLE, else 0.
  - o_hresp_m0/m1=0.
- Address mux: o_haddr/o_htrans/o_hwrite/o_hsize/o_hburst come from the manager selected by gnt.
- Data mux: o_hwdata comes from downer; it is 0 when downer=none.
- Read data: o_hrdata_m0 and o_hrdata_m1 both equal i_hrdata.
- Response: o_hresp_mN = i_hresp when downer==N, else 0.
- Ready:
  - Granted manager: o_hready = i_hreadyout.
  - Ungranted manager: o_hready = 1 if its htrans==IDLE, else 0 (stalled; the manager holds its address and control stable).
- Data owner update on every edge with i_hreadyout=1:
  - downer = gnt if the forwarded htrans is NONSEQ or SEQ.
  - downer = none if the forwarded htrans is IDLE or BUSY.
- Burst lock, on an accepted NONSEQ (i_hreadyout=1):
  - beats = 3 for hburst 010/011, 7 for 100/101, 15 for 110/111, 0 for SINGLE or INCR.
  - Each accepted SEQ decrements beats; beats saturates at 0.
- Re-arbitration occurs only on an edge where all of the following hold:
  - i_hreadyout=1;
  - the forwarded htrans==IDLE;
  - beats==0.
- Arbitration rule at that edge:
  - Only the other manager requests (htrans != IDLE): gnt switches to it.
  - Both request: the manager != last wins.
  - Neither requests, or only the owner requests: gnt is parked unchanged.
  - last is updated to the new gnt on every switch.
- Arbitration latency: the switch is visible on o_hmaster the next cycle. The new owner's NONSEQ is forwarded in that cycle, giving exactly one IDLE bubble on the subordinate bus.
- Consequence of the rule: a manager never loses the grant with a pending data phase, so downer always equals gnt or none.
- A manager that never issues IDLE keeps the grant indefinitely. This is intended; managers must insert IDLE to release the bus.
- Protocol violations:
  - IDLE mid-burst with beats>0: no grant release; beats is held until the burst completes or reset.
  - An ERROR response (i_hresp=1) clears beats to 0.
- Reset asserted mid-transfer: all registers return to reset values immediately (asynchronous); no transfer is replayed.

Test Plan:
- Reset, both managers IDLE -> o_hmaster=0, o_hready_m0=o_hready_m1=1, o_htrans=00.
- m0 SINGLE write 0x10/0xAA, m1 IDLE -> subordinate sees addr 0x10 then hwdata 0xAA next cycle; o_hresp_m1 stays 0.
- m0 INCR4 read from 0x20 while m1 requests NONSEQ at 0x100 -> m0's 4 beats 0x20..0x2C are uninterrupted with o_hready_m1=0 throughout; after m0 drives IDLE, o_hmaster=1 next cycle and 0x100 is forwarded.
- Both issue NONSEQ simultaneously after reset (last=1) -> m0 wins; after m0 drives IDLE, m1 wins; on a repeat collision, m0 wins.
- WAIT_READ=2 subordinate, m1 read at 0x40 while m0 requests -> grant is not switched until i_hreadyout=1 with m1 IDLE; o_hrdata_m1 is sampled correctly.
- Reset pulsed low during the 3rd beat of m1's INCR8 -> o_hmaster=0, beats=0, o_htrans reflects m0 immediately.
